// File: rtl/seradd_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and size helpers.
package seradd_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter width for n digits, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seradd_digit_add.sv
// Combinational DIGIT-bit ripple adder built from per-bit full-add cells.
// o_cmsb is the carry into the top bit, used for signed overflow.
module seradd_digit_add #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[DIGIT];
  assign o_cmsb = w_c[DIGIT-1];

endmodule

// File: rtl/seradd_digit.sv
// Digit-serial add/subtract, DIGIT bits per clock, LSD first, start/busy/done handshake.
// Optional zero/neg flag outputs are built only when SERADD_FLAGS_EN is defined.
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | one digit per cycle, counter 0..NDIG-1
//   DONE   | results updated, done high for one cycle; start accepted here
module seradd_digit
  import seradd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
`ifdef SERADD_FLAGS_EN
  ,
  output logic             o_zero,
  output logic             o_neg
`endif
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_w(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("seradd_digit: DIGIT must divide WIDTH");
  end

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ovf;

  logic [DIGIT-1:0] w_dsum;
  logic             w_dco, w_dcmsb;
  logic [WIDTH-1:0] w_a_next, w_b_next, w_res_next;

  seradd_digit_add #(.DIGIT(DIGIT)) u_add (
    .i_a    (r_a[DIGIT-1:0]),
    .i_b    (r_b[DIGIT-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_dsum),
    .o_cout (w_dco),
    .o_cmsb (w_dcmsb)
  );

  // Result fills from the top so the last digit lands in the MSBs.
  if (DIGIT == WIDTH) begin : g_single
    assign w_a_next   = '0;
    assign w_b_next   = '0;
    assign w_res_next = w_dsum;
  end else begin : g_multi
    assign w_a_next   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
    assign w_b_next   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
    assign w_res_next = {w_dsum, r_res[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_cin ^ i_sub;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a     <= w_a_next;
          r_b     <= w_b_next;
          r_res   <= w_res_next;
          r_carry <= w_dco;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_sum   <= w_res_next;
            r_cout  <= w_dco;
            r_ovf   <= w_dcmsb ^ w_dco;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SERADD_FLAGS_EN
  logic r_zero, r_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (r_state == S_RUN && r_cnt == LAST) begin
      r_zero <= (w_res_next == '0);
      r_neg  <= w_res_next[WIDTH-1];
    end
  end

  assign o_zero = r_zero;
  assign o_neg  = r_neg;
`endif

  assign o_busy = (r_state == S_RUN);
  assign o_done = (r_state == S_DONE);
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_seradd_digit.sv
// Directed-vector bench for seradd_digit: 8/2 main instance plus 16/16 and 16/4 instances.
// Flag outputs are checked only when SERADD_FLAGS_EN is defined.
module tb_seradd_digit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Main DUT: WIDTH=8, DIGIT=2
  logic       start, sub, cin;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;
`ifdef SERADD_FLAGS_EN
  logic       zero, neg;
`endif

  seradd_digit #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_sub(sub), .i_a(a), .i_b(b), .i_cin(cin),
    .o_busy(busy), .o_done(done), .o_sum(sum), .o_cout(cout), .o_ovf(ovf)
`ifdef SERADD_FLAGS_EN
    , .o_zero(zero), .o_neg(neg)
`endif
  );

  // Wide DUTs: index 0 -> DIGIT=16, index 1 -> DIGIT=4
  logic        w_start [2];
  logic        w_sub [2];
  logic        w_cin [2];
  logic [15:0] w_a [2];
  logic [15:0] w_b [2];
  logic        w_busy [2];
  logic        w_done [2];
  logic        w_cout [2];
  logic        w_ovf [2];
  logic [15:0] w_sum [2];
`ifdef SERADD_FLAGS_EN
  logic        w_zero [2];
  logic        w_neg [2];
`endif

  seradd_digit #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .i_start(w_start[0]), .i_sub(w_sub[0]), .i_a(w_a[0]), .i_b(w_b[0]),
    .i_cin(w_cin[0]), .o_busy(w_busy[0]), .o_done(w_done[0]), .o_sum(w_sum[0]),
    .o_cout(w_cout[0]), .o_ovf(w_ovf[0])
`ifdef SERADD_FLAGS_EN
    , .o_zero(w_zero[0]), .o_neg(w_neg[0])
`endif
  );

  seradd_digit #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_start(w_start[1]), .i_sub(w_sub[1]), .i_a(w_a[1]), .i_b(w_b[1]),
    .i_cin(w_cin[1]), .o_busy(w_busy[1]), .o_done(w_done[1]), .o_sum(w_sum[1]),
    .o_cout(w_cout[1]), .o_ovf(w_ovf[1])
`ifdef SERADD_FLAGS_EN
    , .o_zero(w_zero[1]), .o_neg(w_neg[1])
`endif
  );

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] e_sum;
    logic       e_cout;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one 8-bit operation; returns busy cycle count and whether done followed.
  task automatic op8(input logic s, input logic [7:0] va, input logic [7:0] vb, input logic c,
                     output int nbusy, output logic saw_done);
    @(negedge clk);
    start = 1'b1; sub = s; a = va; b = vb; cin = c;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 20) begin
      nbusy++;
      @(negedge clk);
    end
    saw_done = done;
  endtask

  task automatic chk_res8(input string name, input logic [7:0] es, input logic ec, input logic eo);
    chk({name, ".sum"}, 32'(sum), 32'(es));
    chk({name, ".cout"}, 32'(cout), 32'(ec));
    chk({name, ".ovf"}, 32'(ovf), 32'(eo));
`ifdef SERADD_FLAGS_EN
    chk({name, ".zero"}, 32'(zero), 32'(es == 8'h00));
    chk({name, ".neg"}, 32'(neg), 32'(es[7]));
`endif
  endtask

  task automatic op16(input int k, input logic s, input logic [15:0] va, input logic [15:0] vb,
                      input logic c, input logic [15:0] es, input logic ec, input logic eo,
                      input int ecyc, input string name);
    int nb;
    @(negedge clk);
    w_start[k] = 1'b1; w_sub[k] = s; w_a[k] = va; w_b[k] = vb; w_cin[k] = c;
    @(negedge clk);
    w_start[k] = 1'b0;
    nb = 0;
    while (w_busy[k] && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    chk({name, ".cycles"}, 32'(nb), 32'(ecyc));
    chk({name, ".done"}, 32'(w_done[k]), 32'd1);
    chk({name, ".sum"}, 32'(w_sum[k]), 32'(es));
    chk({name, ".cout"}, 32'(w_cout[k]), 32'(ec));
    chk({name, ".ovf"}, 32'(w_ovf[k]), 32'(eo));
`ifdef SERADD_FLAGS_EN
    chk({name, ".zero"}, 32'(w_zero[k]), 32'(es == 16'h0000));
    chk({name, ".neg"}, 32'(w_neg[k]), 32'(es[15]));
`endif
  endtask

  initial begin
    int nb;
    logic sd;
    logic seen;

    vecs[0] = '{1'b0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h0A, 8'h03, 1'b1, 8'h06, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    start = 0; sub = 0; cin = 0; a = '0; b = '0;
    for (int k = 0; k < 2; k++) begin
      w_start[k] = 0; w_sub[k] = 0; w_cin[k] = 0; w_a[k] = '0; w_b[k] = '0;
    end

    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.sum", 32'(sum), 32'd0);
    chk("rst.cout", 32'(cout), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, nb, sd);
      chk($sformatf("vec%0d.cycles", i), 32'(nb), 32'd4);
      chk($sformatf("vec%0d.done", i), 32'(sd), 32'd1);
      chk_res8($sformatf("vec%0d", i), vecs[i].e_sum, vecs[i].e_cout, vecs[i].e_ovf);
      @(negedge clk);
      chk($sformatf("vec%0d.done_pulse", i), 32'(done), 32'd0);
    end

    // start during RUN is ignored; outputs hold previous result (80+80) while running
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h3C; b = 8'h0F; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("ign.busy1", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b1; sub = 1'b1; a = 8'h80; b = 8'h01; cin = 1'b1;
    chk("ign.hold_sum", 32'(sum), 32'h00);
    chk("ign.hold_cout", 32'(cout), 32'd1);
    @(negedge clk);
    start = 1'b0;
    nb = 2;
    while (busy && nb < 20) begin
      nb++;
      @(negedge clk);
    end
    chk("ign.cycles", 32'(nb), 32'd4);
    chk("ign.done", 32'(done), 32'd1);
    chk_res8("ign", 8'h4B, 1'b0, 1'b0);

    // start in the DONE cycle is accepted back-to-back
    start = 1'b1; sub = 1'b1; a = 8'h05; b = 8'h07; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b.busy", 32'(busy), 32'd1);
    chk("b2b.done", 32'(done), 32'd0);
    nb = 0;
    while (busy && nb < 20) begin
      nb++;
      @(negedge clk);
    end
    chk("b2b.cycles", 32'(nb), 32'd4);
    chk("b2b.done2", 32'(done), 32'd1);
    chk_res8("b2b", 8'hFE, 1'b0, 1'b0);

    // reset in the 3rd RUN cycle aborts and clears results
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h7F; b = 8'h01; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.done", 32'(done), 32'd0);
    chk("rst_mid.sum", 32'(sum), 32'd0);
    chk("rst_mid.cout", 32'(cout), 32'd0);
    chk("rst_mid.ovf", 32'(ovf), 32'd0);
`ifdef SERADD_FLAGS_EN
    chk("rst_mid.zero", 32'(zero), 32'd0);
    chk("rst_mid.neg", 32'(neg), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("rst_mid.no_done", 32'(seen), 32'd0);
    op8(1'b0, 8'h3C, 8'h0F, 1'b0, nb, sd);
    chk("rst_mid.new_cycles", 32'(nb), 32'd4);
    chk("rst_mid.new_done", 32'(sd), 32'd1);
    chk_res8("rst_mid.new", 8'h4B, 1'b0, 1'b0);

    op16(0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1, "w16");
    op16(0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1, "w16b");
    op16(1, 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 4, "w4");
    op16(1, 1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 4, "w4sub");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seradd_digit.md
Name: seradd_digit

Overview:
- Parametrised, multi-cycle digit-serial adder/subtractor for the ALU datapath.
- Processes operands DIGIT bits per clock, least-significant digit first.
- Uses a ripple chain of DIGIT full-add cells per cycle, with the carry held in a register between cycles.
- Uses a start/busy/done handshake to the ALU controller and produces sum, carry-out and signed-overflow.

Parameters:
- WIDTH, 8, operand and result width in bits.
- DIGIT, 2, bits processed per cycle. Must divide WIDTH exactly; a mismatch is a compile-time error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request new operation; sampled only when busy=0.
- sub  input  1  0 = add, 1 = subtract; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in for add, borrow-in for subtract; captured with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when results update.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB (for subtract, 1 = no borrow).
- ovf  output  1  two's-complement overflow.
- zero  output  1  sum==0 (only with SERADD_FLAGS_EN).
- neg  output  1  sum[WIDTH-1] (only with SERADD_FLAGS_EN).

Behaviour:
- Reset (rst_n=0, asynchronous): busy=0, done=0, sum=0, cout=0, ovf=0, zero=0, neg=0. FSM goes to IDLE; internal shift registers and carry register are cleared.
- Reset asserted mid-operation aborts the operation: no done pulse, and the previous results are lost (cleared to 0).
- NDIG = WIDTH/DIGIT.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1, digit counter 0..NDIG-1.
  - DONE: busy=0, done=1 for exactly one cycle.
- IDLE or DONE, start=1 at edge T0:
  - Capture a into the A shift register.
  - Capture b into the B shift register, inverted when sub=1.
  - Set the carry register to cin ^ sub, so sub=1,cin=0 computes a-b and sub=1,cin=1 computes a-b-1.
  - Clear the counter and go to RUN.
- DONE with start=0 goes to IDLE.
- RUN, each edge T1..TNDIG:
  - Add the low DIGIT bits of the A and B shift registers plus the carry register.
  - Shift the digit result into the result shift register and update the carry register.
  - Increment the counter.
- At edge TNDIG (counter==NDIG-1):
  - Copy the result register to sum and the final carry to cout.
  - Set ovf = carry into MSB ^ carry out of MSB.
  - Go to DONE.
- Timing: done is high in the cycle following edge TNDIG, i.e. NDIG cycles after busy rises.
- sum/cout/ovf/zero/neg change only on the completion edge and hold their values otherwise, including throughout a subsequent RUN.
- start while busy=1 is ignored, with no effect on the operation in progress.
- start in the DONE cycle is accepted, giving back-to-back operations with no idle gap.
- DIGIT==WIDTH: NDIG=1, a single RUN cycle.
- Arithmetic is modulo 2^WIDTH. Operands are treated as signed only for ovf.

Optional Feature:
- Macro SERADD_FLAGS_EN.
- Defined: zero and neg ports exist and are registered on the completion edge with sum (reset 0).
- Undefined: zero and neg ports and their logic are absent; all other behaviour is unchanged.

Decomposition:
- Shared package seradd_pkg holds:
  - the FSM state encoding (IDLE, RUN, DONE);
  - the NDIG derivation function;
  - the counter-width function clog2(NDIG), minimum 1.
- One sub-module: digit_add. It is a purely combinational DIGIT-bit ripple adder built from per-bit full-add cells, with outputs digit sum, carry out and carry into the top bit (the last feeds ovf).

Test Plan (WIDTH=8, DIGIT=2 unless stated):
- Add a=8'h3C, b=8'h0F, cin=0 -> sum=8'h4B, cout=0, ovf=0; busy high 4 cycles; done pulses one cycle after busy falls.
- Add a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1, neg=1. Add a=8'hFF, b=8'h01 -> sum=8'h00, cout=1, ovf=0, zero=1.
- Sub a=8'h05, b=8'h07, cin=0 -> sum=8'hFE, cout=0, ovf=0. Sub a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- start pulsed again in the 2nd RUN cycle with different operands -> ignored; the first result is unchanged. start in the DONE cycle -> accepted; busy reasserts next cycle.
- rst_n low in the 3rd RUN cycle -> busy, done and all outputs 0 immediately; no done pulse after release; a new start then completes normally.
- WIDTH=16, DIGIT=16: a=16'hFFFF, b=16'h0001 -> sum=0, cout=1 after 1 RUN cycle. WIDTH=16, DIGIT=4 -> 4 RUN cycles.
